// File: rtl/control_sequencer_if.sv
// Control bundle between the control sequencer (master) and the Mini SRC datapath (slave).
// Signal names match the datapath's existing control inputs.
interface control_sequencer_if #(
  parameter int T_WIDTH = 4
);
  logic               run;
  logic               mem_rdy;
  logic [31:0]        ir;
  logic [4:0]         BusDataSelect;
  logic [3:0]         GP_addr;
  logic               e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
  logic               incPC;
  logic               MDR_read;
  logic [3:0]         ALU_op;
  logic [T_WIDTH-1:0] state;
  logic               halted;
  logic               illegal;

  modport master (
    input  run, mem_rdy, ir,
    output BusDataSelect, GP_addr, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
           incPC, MDR_read, ALU_op, state, halted, illegal
  );

  modport slave (
    output run, mem_rdy, ir,
    input  BusDataSelect, GP_addr, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
           incPC, MDR_read, ALU_op, state, halted, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2) then 3-register ALU execute (T3-T5[,T6]).
// Optional feature: define MULDIV_EN to decode mul/div (T5 writes LO, T6 writes HI).
module control_sequencer #(
  parameter int T_WIDTH  = 4,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic                clock,
  input  logic                clear,
  control_sequencer_if.master ctl
);

  typedef enum logic [T_WIDTH-1:0] {
    T0   = T_WIDTH'(0),
    T1   = T_WIDTH'(1),
    T2   = T_WIDTH'(2),
    T3   = T_WIDTH'(3),
    T4   = T_WIDTH'(4),
    T5   = T_WIDTH'(5),
    T6   = T_WIDTH'(6),
    HALT = T_WIDTH'(7)
  } state_t;

  localparam logic [4:0] BUS_HI    = 5'b10000;
  localparam logic [4:0] BUS_ZHIGH = 5'b10010;
  localparam logic [4:0] BUS_ZLOW  = 5'b10011;
  localparam logic [4:0] BUS_PC    = 5'b10100;
  localparam logic [4:0] BUS_MDR   = 5'b10101;
  localparam logic [4:0] OP_MUL    = 5'b01111;
  localparam logic [4:0] OP_DIV    = 5'b10000;
  localparam logic [4:0] OP_HALT   = 5'b11010;

  state_t     state_q;
  logic       pc_done;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       alu_ok;
  logic [3:0] alu_sel;
  logic       is_muldiv;
  logic       unused_ir;

  // Returns {supported, ALU_op} for an opcode.
  function automatic logic [4:0] alu_decode(input logic [4:0] opc);
    logic [4:0] res;
    res = 5'b0_0000;
    case (opc)
      5'b00000: res = 5'b1_0000;
      5'b00001: res = 5'b1_0001;
      5'b00010: res = 5'b1_0010;
      5'b00011: res = 5'b1_0011;
      5'b00100: res = 5'b1_1010;
      5'b00101: res = 5'b1_1100;
      5'b00110: res = 5'b1_1011;
      5'b00111: res = 5'b1_1000;
      5'b01000: res = 5'b1_1001;
`ifdef MULDIV_EN
      OP_MUL:   res = 5'b1_0110;
      OP_DIV:   res = 5'b1_0111;
`endif
      default:  res = 5'b0_0000;
    endcase
    return res;
  endfunction

  assign op               = ctl.ir[31:27];
  assign ra               = ctl.ir[26:23];
  assign rb               = ctl.ir[22:19];
  assign rc               = ctl.ir[18:15];
  assign {alu_ok, alu_sel} = alu_decode(op);
  assign unused_ir        = ^ctl.ir[14:0];
`ifdef MULDIV_EN
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
`else
  assign is_muldiv = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation results.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= T0;
      pc_done <= 1'b0;
    end else begin
      // pc_done marks every T1 cycle after the first, so PC loads once per fetch.
      pc_done <= (state_q == T1);
      case (state_q)
        T0:      if (ctl.run) state_q <= T1;
        T1:      if (!MEM_WAIT || ctl.mem_rdy) state_q <= T2;
        T2:      state_q <= T3;
        T3: begin
          if (op == OP_HALT)  state_q <= HALT;
          else if (alu_ok)    state_q <= T4;
          else                state_q <= T0;
        end
        T4:      state_q <= T5;
        T5:      state_q <= is_muldiv ? T6 : T0;
`ifdef MULDIV_EN
        T6:      state_q <= T0;
`endif
        HALT:    state_q <= HALT;
        default: state_q <= T0;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    ctl.BusDataSelect = BUS_PC;
    ctl.GP_addr       = 4'd0;
    ctl.ALU_op        = 4'b0000;
    ctl.e_PC  = 1'b0; ctl.e_IR  = 1'b0; ctl.e_Y   = 1'b0;
    ctl.e_Z   = 1'b0; ctl.e_HI  = 1'b0; ctl.e_LO  = 1'b0;
    ctl.e_MDR = 1'b0; ctl.e_MAR = 1'b0; ctl.e_GP  = 1'b0;
    ctl.incPC    = 1'b0;
    ctl.MDR_read = 1'b0;
    ctl.illegal  = 1'b0;
    case (state_q)
      T0: begin
        ctl.e_MAR = ctl.run;
        ctl.incPC = ctl.run;
        ctl.e_Z   = ctl.run;
      end
      T1: begin
        ctl.BusDataSelect = BUS_ZLOW;
        ctl.e_PC          = !pc_done;
        ctl.MDR_read      = 1'b1;
        ctl.e_MDR         = 1'b1;
      end
      T2: begin
        ctl.BusDataSelect = BUS_MDR;
        ctl.e_IR          = 1'b1;
      end
      T3: begin
        ctl.BusDataSelect = {1'b0, rb};
        ctl.GP_addr       = rb;
        ctl.e_Y           = 1'b1;
        ctl.illegal       = (op != OP_HALT) && !alu_ok;
      end
      T4: begin
        ctl.BusDataSelect = {1'b0, rc};
        ctl.GP_addr       = rc;
        ctl.ALU_op        = alu_sel;
        ctl.e_Z           = 1'b1;
      end
      T5: begin
        ctl.BusDataSelect = BUS_ZLOW;
        ctl.GP_addr       = ra;
        ctl.e_GP          = !is_muldiv;
        ctl.e_LO          = is_muldiv;
      end
`ifdef MULDIV_EN
      T6: begin
        ctl.BusDataSelect = BUS_ZHIGH;
        ctl.e_HI          = 1'b1;
      end
`endif
      default: ctl.BusDataSelect = BUS_PC;
    endcase
  end

  assign ctl.state  = state_q;
  assign ctl.halted = (state_q == HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer: fetch/execute timing, memory stall,
// illegal and halt opcodes, and (with MULDIV_EN) mul sequencing plus mid-instruction clear.
module tb_control_sequencer;

  logic clock = 1'b0;
  logic clear;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  control_sequencer_if #(.T_WIDTH(4)) ctl ();

  control_sequencer #(.T_WIDTH(4), .MEM_WAIT(1'b1)) dut (
    .clock (clock),
    .clear (clear),
    .ctl   (ctl)
  );

  localparam logic [10:0] E_PC  = 11'h400, E_IR  = 11'h200, E_Y   = 11'h100, E_Z   = 11'h080;
  localparam logic [10:0] E_HI  = 11'h040, E_LO  = 11'h020, E_MDR = 11'h010, E_MAR = 11'h008;
  localparam logic [10:0] E_GP  = 11'h004, INC   = 11'h002, MRD   = 11'h001, NONE  = 11'h000;
  localparam logic [10:0] EN_T0 = E_MAR | E_Z | INC;
  localparam logic [10:0] EN_T1 = E_PC | E_MDR | MRD;
  localparam logic [10:0] EN_ST = E_MDR | MRD;

  function automatic logic [10:0] en_vec();
    return {ctl.e_PC, ctl.e_IR, ctl.e_Y, ctl.e_Z, ctl.e_HI, ctl.e_LO,
            ctl.e_MDR, ctl.e_MAR, ctl.e_GP, ctl.incPC, ctl.MDR_read};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_cycle(input string tag, input logic [3:0] st, input logic [4:0] bus,
                           input logic [10:0] en, input logic [3:0] alu, input logic [3:0] gp,
                           input logic ill, input logic hlt);
    check({tag, " state"},   32'(ctl.state),         32'(st));
    check({tag, " bus"},     32'(ctl.BusDataSelect), 32'(bus));
    check({tag, " enables"}, 32'(en_vec()),          32'(en));
    check({tag, " alu_op"},  32'(ctl.ALU_op),        32'(alu));
    check({tag, " gp_addr"}, 32'(ctl.GP_addr),       32'(gp));
    check({tag, " illegal"}, 32'(ctl.illegal),       32'(ill));
    check({tag, " halted"},  32'(ctl.halted),        32'(hlt));
  endtask

  // Outputs are sampled 2-3 time units after the rising edge, away from both edges.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [4:0] ops  [8];
    logic [3:0] alus [8];
    ops  = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00110, 5'b00111, 5'b01000};
    alus = '{4'b0000,  4'b0001,  4'b0010,  4'b0011,  4'b1010,  4'b1011,  4'b1000,  4'b1001};

    // Reset with run low, then idle in T0.
    clear = 1'b1; ctl.run = 1'b0; ctl.mem_rdy = 1'b0; ctl.ir = 32'h0;
    tick(); tick();
    clear = 1'b0;
    settle();
    exp_cycle("reset", 4'd0, 5'b10100, NONE, 4'b0000, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle%0d state", i), 32'(ctl.state), 32'd0);
      check($sformatf("idle%0d enables", i), 32'(en_vec()), 32'(NONE));
    end

    // shra R4,R3,R7: op 00101, Ra 0100, Rb 0011, Rc 0111 -> 32'h2A1B8000.
    ctl.ir = 32'h2A1B8000; ctl.run = 1'b1; ctl.mem_rdy = 1'b1;
    settle();
    exp_cycle("shra T0", 4'd0, 5'b10100, EN_T0, 4'b0000, 4'd0, 1'b0, 1'b0);
    tick(); exp_cycle("shra T1", 4'd1, 5'b10011, EN_T1, 4'b0000, 4'd0, 1'b0, 1'b0);
    tick(); exp_cycle("shra T2", 4'd2, 5'b10101, E_IR,  4'b0000, 4'd0, 1'b0, 1'b0);
    tick(); exp_cycle("shra T3", 4'd3, 5'b00011, E_Y,   4'b0000, 4'd3, 1'b0, 1'b0);
    tick(); exp_cycle("shra T4", 4'd4, 5'b00111, E_Z,   4'b1100, 4'd7, 1'b0, 1'b0);
    tick(); ctl.run = 1'b0; settle();
    exp_cycle("shra T5", 4'd5, 5'b10011, E_GP,  4'b0000, 4'd4, 1'b0, 1'b0);
    tick(); exp_cycle("shra end", 4'd0, 5'b10100, NONE, 4'b0000, 4'd0, 1'b0, 1'b0);

    // 32'h2A318000 decodes as shra Ra=4, Rb=6, Rc=3; memory stalls for 3 T1 cycles.
    ctl.ir = 32'h2A318000; ctl.run = 1'b1; ctl.mem_rdy = 1'b0;
    settle();
    exp_cycle("stall T0", 4'd0, 5'b10100, EN_T0, 4'b0000, 4'd0, 1'b0, 1'b0);
    tick(); exp_cycle("stall T1c1", 4'd1, 5'b10011, EN_T1, 4'b0000, 4'd0, 1'b0, 1'b0);
    tick(); exp_cycle("stall T1c2", 4'd1, 5'b10011, EN_ST, 4'b0000, 4'd0, 1'b0, 1'b0);
    tick(); exp_cycle("stall T1c3", 4'd1, 5'b10011, EN_ST, 4'b0000, 4'd0, 1'b0, 1'b0);
    tick(); ctl.mem_rdy = 1'b1; settle();
    exp_cycle("stall T1c4", 4'd1, 5'b10011, EN_ST, 4'b0000, 4'd0, 1'b0, 1'b0);
    tick(); exp_cycle("stall T2", 4'd2, 5'b10101, E_IR, 4'b0000, 4'd0, 1'b0, 1'b0);
    tick(); exp_cycle("stall T3", 4'd3, 5'b00110, E_Y,  4'b0000, 4'd6, 1'b0, 1'b0);
    tick(); exp_cycle("stall T4", 4'd4, 5'b00011, E_Z,  4'b1100, 4'd3, 1'b0, 1'b0);
    tick(); ctl.run = 1'b0; settle();
    exp_cycle("stall T5", 4'd5, 5'b10011, E_GP, 4'b0000, 4'd4, 1'b0, 1'b0);
    tick(); check("stall end state", 32'(ctl.state), 32'd0);

    // ALU opcode table with Ra=1, Rb=2, Rc=3.
    for (int k = 0; k < 8; k++) begin
      ctl.ir = {ops[k], 4'd1, 4'd2, 4'd3, 15'd0}; ctl.run = 1'b1;
      settle();
      tick(); tick(); tick();
      exp_cycle($sformatf("op%0d T3", k), 4'd3, 5'b00010, E_Y, 4'b0000, 4'd2, 1'b0, 1'b0);
      tick();
      exp_cycle($sformatf("op%0d T4", k), 4'd4, 5'b00011, E_Z, alus[k], 4'd3, 1'b0, 1'b0);
      tick(); ctl.run = 1'b0; settle();
      exp_cycle($sformatf("op%0d T5", k), 4'd5, 5'b10011, E_GP, 4'b0000, 4'd1, 1'b0, 1'b0);
      tick();
      check($sformatf("op%0d end state", k), 32'(ctl.state), 32'd0);
    end

    // Unsupported opcode 11111: one-cycle illegal pulse in T3, no GP write, back to T0.
    ctl.ir = 32'hF8000000; ctl.run = 1'b1;
    settle();
    tick(); check("ill T1 e_GP", 32'(ctl.e_GP), 32'd0);
    tick(); check("ill T2 e_GP", 32'(ctl.e_GP), 32'd0);
    tick(); ctl.run = 1'b0; settle();
    exp_cycle("ill T3", 4'd3, 5'b00000, E_Y, 4'b0000, 4'd0, 1'b1, 1'b0);
    tick(); exp_cycle("ill end", 4'd0, 5'b10100, NONE, 4'b0000, 4'd0, 1'b0, 1'b0);
    tick(); check("ill idle illegal", 32'(ctl.illegal), 32'd0);

    // Halt opcode 11010: sticky HALT despite run=1, released only by clear.
    ctl.ir = 32'hD0000000; ctl.run = 1'b1;
    settle();
    tick(); tick(); tick();
    exp_cycle("halt T3", 4'd3, 5'b00000, E_Y, 4'b0000, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_cycle($sformatf("halt%0d", i), 4'd7, 5'b10100, NONE, 4'b0000, 4'd0, 1'b0, 1'b1);
    end
    clear = 1'b1;
    tick(); clear = 1'b0; ctl.run = 1'b0; settle();
    exp_cycle("halt cleared", 4'd0, 5'b10100, NONE, 4'b0000, 4'd0, 1'b0, 1'b0);

`ifdef MULDIV_EN
    // mul R2,R5,R9: op 01111, Ra 0010, Rb 0101, Rc 1001 -> 32'h792C8000.
    ctl.ir = 32'h792C8000; ctl.run = 1'b1;
    settle();
    tick(); tick(); tick();
    exp_cycle("mul T3", 4'd3, 5'b00101, E_Y,  4'b0000, 4'd5, 1'b0, 1'b0);
    tick(); exp_cycle("mul T4", 4'd4, 5'b01001, E_Z, 4'b0110, 4'd9, 1'b0, 1'b0);
    tick(); ctl.run = 1'b0; settle();
    exp_cycle("mul T5", 4'd5, 5'b10011, E_LO, 4'b0000, 4'd2, 1'b0, 1'b0);
    tick(); exp_cycle("mul T6", 4'd6, 5'b10010, E_HI, 4'b0000, 4'd0, 1'b0, 1'b0);
    tick(); check("mul end state", 32'(ctl.state), 32'd0);

    // Same instruction aborted by clear during T4: no LO/HI write follows.
    ctl.run = 1'b1;
    settle();
    tick(); tick(); tick(); tick();
    check("abort T4 state", 32'(ctl.state), 32'd4);
    clear = 1'b1; ctl.run = 1'b0;
    tick(); exp_cycle("abort cleared", 4'd0, 5'b10100, NONE, 4'b0000, 4'd0, 1'b0, 1'b0);
    clear = 1'b0;
    tick(); exp_cycle("abort idle", 4'd0, 5'b10100, NONE, 4'b0000, 4'd0, 1'b0, 1'b0);
`else
    // Without mul/div support, mul (01111) is an illegal opcode.
    ctl.ir = 32'h792C8000; ctl.run = 1'b1;
    settle();
    tick(); tick(); tick(); ctl.run = 1'b0; settle();
    exp_cycle("mul ill T3", 4'd3, 5'b00101, E_Y, 4'b0000, 4'd5, 1'b1, 1'b0);
    tick(); exp_cycle("mul ill end", 4'd0, 5'b10100, NONE, 4'b0000, 4'd0, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
